bus_cmd_master: RTL and testbench
=================================

// Module: bus_cmd_master
// PURPOSE
//  Bus initiator for the peripheral register space, driven by a serial byte stream.
//  It decodes read/write command frames arriving from a host-side UART receiver.
//  It issues single-word transactions on the peripheral bus (addr/data/sel/wr) and
//  returns the results as bytes to a UART transmitter. Used for debug, bring-up and
//  loader access without CPU involvement.
// PARAMETERS
//  TIMEOUT_CYCLES  100000  max idle cycles between bytes of one frame before abort
//  RD_LATENCY      1       cycles from read strobe (sel_o=1, wr_o=0) to valid data_i
// PORTS
//  clk_i       in   1   clock
//  rst_i       in   1   reset, synchronous, active-high
//  rx_data_i   in   8   received byte
//  rx_valid_i  in   1   one-cycle strobe, rx_data_i valid
//  tx_data_o   out  8   byte to transmit
//  tx_valid_o  out  1   tx_data_o valid; held until accepted
//  tx_ready_i  in   1   transmitter accepts byte when tx_valid_o & tx_ready_i
//  addr_o      out  32  bus address
//  data_o      out  32  bus write data
//  data_i      in   32  bus read data
//  sel_o       out  1   bus select, one-cycle strobe per transaction
//  wr_o        out  1   bus write enable, qualified by sel_o
//  busy_o      out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (sync, rst_i=1 at posedge): state IDLE; all outputs 0; counters and shift regs 0.
//  Frame format, multi-byte fields MSB first:
//   write: 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0 -> response 0x4B 'K'
//   read:  0x52 'R', A3 A2 A1 A0             -> response D3 D2 D1 D0
//   any other first byte                      -> response 0x3F '?', no bus access
//  States:
//   IDLE:   on rx_valid_i, latch opcode. W/R -> ADDR. Else load '?' -> RESP.
//   ADDR:   shift 4 bytes into addr_o ({addr_o[23:0],rx_data_i}). After 4th byte, W -> DATA, R -> BUS.
//   DATA:   shift 4 bytes into data_o likewise. After 4th byte -> BUS.
//   BUS:    exactly one cycle sel_o=1 with wr_o=1 (W) or wr_o=0 (R). W -> load 'K' -> RESP.
//           R -> WAIT.
//   WAIT:   count RD_LATENCY cycles after the strobe, then capture data_i into the
//           response shift reg, byte count 4 -> RESP.
//   RESP:   tx_valid_o=1 with current byte. On tx_valid_o & tx_ready_i, advance to next
//           byte, or go to IDLE after the last byte (tx_valid_o=0 that cycle).
//  sel_o and wr_o are 0 in all states except BUS. addr_o and data_o hold their last
//   values afterwards.
//  rx_valid_i is ignored (byte dropped) in BUS, WAIT and RESP. The frame is not affected.
//  Timeout: in ADDR and DATA, a counter clears on each rx_valid_i and increments
//   otherwise. When it reaches TIMEOUT_CYCLES the FSM returns to IDLE: frame discarded,
//   no bus access, no response.
//  Byte counter is 2 bits and wraps 3->0 on the field's last byte. There are no
//   partial-word accesses.
//  rx_valid_i arriving in the same cycle as the timeout expiry: the timeout wins and
//   the byte is dropped.
//  Reset mid-frame or mid-response aborts immediately. A pending tx byte is withdrawn
//   and no bus strobe follows.
//  Latency: bus strobe in the cycle after the last frame byte is sampled. The first
//   response byte is valid 1 cycle after BUS (W) or RD_LATENCY+1 cycles after BUS (R).
// TESTING
//  1. Write: rx 57 01 10 40 10 00 00 00 AA -> one cycle sel_o=1 wr_o=1
//     addr_o=0x01104010 data_o=0x000000AA; then tx 0x4B; busy_o=0 after accept.
//  2. Read: rx 52 01 20 40 00, data_i=0x12345678 at RD_LATENCY -> exactly one strobe
//     sel_o=1 wr_o=0 addr_o=0x01204000; tx 12 34 56 78 in order.
//  3. Backpressure: during test 2 hold tx_ready_i=0 for 20 cycles before each byte ->
//     tx_data_o stable while tx_valid_o=1; no byte lost or duplicated.
//  4. Bad opcode: rx 0x00 -> tx 0x3F, sel_o never asserted. Next, a valid R frame
//     executes normally.
//  5. Timeout: (TIMEOUT_CYCLES=16) rx 57 01 10, then idle 16 cycles -> IDLE, no strobe,
//     no tx; then full test-1 frame succeeds.
//  6. Reset: assert rst_i after 3rd address byte and again during RESP -> all outputs 0
//     next cycle, no strobe; subsequent frames correct.

Source files
------------

// File: rtl/bus_cmd_master.sv
// bus_cmd_master: UART command frames in, single-word peripheral bus transactions out, result bytes back to UART
module bus_cmd_master #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int RD_LATENCY     = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   input  logic [31:0] data_i,
   output logic        sel_o,
   output logic        wr_o,
   output logic        busy_o
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int LW = $clog2(RD_LATENCY + 1);
   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, WAIT, RESP} state_t;
   state_t        state;
   logic          is_wr;
   logic [1:0]    cnt;
   logic [TW-1:0] tmo;
   logic [LW-1:0] lat;
   logic [23:0]   resp;
   logic          last_field;
   always_comb last_field = !(state == ADDR && is_wr);
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         is_wr      <= 1'b0;
         cnt        <= '0;
         tmo        <= '0;
         lat        <= '0;
         resp       <= '0;
         tx_data_o  <= '0;
         tx_valid_o <= 1'b0;
         addr_o     <= '0;
         data_o     <= '0;
         sel_o      <= 1'b0;
         wr_o       <= 1'b0;
         busy_o     <= 1'b0;
      end else begin
         sel_o <= 1'b0;
         wr_o  <= 1'b0;
         case (state)
            IDLE: if (rx_valid_i) begin
               busy_o <= 1'b1;
               cnt    <= '0;
               tmo    <= '0;
               if (rx_data_i == 8'h57 || rx_data_i == 8'h52) begin
                  is_wr <= rx_data_i == 8'h57;
                  state <= ADDR;
               end else begin
                  tx_data_o  <= 8'h3F;
                  tx_valid_o <= 1'b1;
                  state      <= RESP;
               end
            end
            ADDR, DATA: begin
               // expiry takes priority over a byte arriving in the same cycle
               if (tmo == TW'(TIMEOUT_CYCLES)) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else if (rx_valid_i) begin
                  tmo <= '0;
                  cnt <= cnt + 2'd1;
                  if (state == ADDR) addr_o <= {addr_o[23:0], rx_data_i};
                  else data_o <= {data_o[23:0], rx_data_i};
                  if (cnt == 2'd3) begin
                     state <= last_field ? BUS : DATA;
                     sel_o <= last_field;
                     wr_o  <= last_field && is_wr;
                  end
               end else tmo <= tmo + 1'b1;
            end
            BUS: begin
               lat <= LW'(1);
               if (is_wr) begin
                  tx_data_o  <= 8'h4B;
                  tx_valid_o <= 1'b1;
                  cnt        <= '0;
                  state      <= RESP;
               end else state <= WAIT;
            end
            WAIT: if (lat == LW'(RD_LATENCY)) begin
               tx_data_o  <= data_i[31:24];
               resp       <= data_i[23:0];
               tx_valid_o <= 1'b1;
               cnt        <= 2'd3;
               state      <= RESP;
            end else lat <= lat + 1'b1;
            RESP: if (tx_ready_i) begin
               // cnt holds the number of bytes still queued behind tx_data_o
               if (cnt == 2'd0) begin
                  tx_valid_o <= 1'b0;
                  busy_o     <= 1'b0;
                  state      <= IDLE;
               end else begin
                  tx_data_o <= resp[23:16];
                  resp      <= {resp[15:0], 8'h00};
                  cnt       <= cnt - 2'd1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bus_cmd_master.sv
// tb_bus_cmd_master: scoreboard bench for bus_cmd_master, bus strobes and tx bytes checked against queued expectations
module tb_bus_cmd_master;
   localparam int TMO = 16;
   localparam int RDL = 1;
   typedef struct packed {logic [31:0] a; logic [31:0] d; logic w;} bus_t;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  rx_data_i = '0;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i = 1'b1;
   logic [31:0] addr_o, data_o;
   logic [31:0] data_i = 32'hDEADBEEF;
   logic        sel_o, wr_o, busy_o;
   logic [31:0] rd_word = '0;
   logic        bp = 1'b0, hold = 1'b0;
   int          n_chk = 0, n_fail = 0;
   bus_t        exp_bus[$];
   logic [7:0]  exp_tx[$];

   bus_cmd_master #(.TIMEOUT_CYCLES(TMO), .RD_LATENCY(RDL)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
      .sel_o(sel_o), .wr_o(wr_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // read data is valid only RDL cycles after a read strobe, garbage otherwise
   always @(posedge clk_i) data_i <= (sel_o && !wr_o) ? rd_word : 32'hDEADBEEF;

   initial begin : ready_drv
      int stall;
      stall = 0;
      forever begin
         @(posedge clk_i); #1;
         if (hold) tx_ready_i = 1'b0;
         else if (!bp) tx_ready_i = 1'b1;
         else if (tx_valid_o && stall >= 20) begin tx_ready_i = 1'b1; stall = 0; end
         else begin tx_ready_i = 1'b0; if (tx_valid_o) stall++; end
      end
   end

   initial begin : monitor
      bus_t       b;
      logic [7:0] t, held;
      logic       pend, armed, prev_v, strobe_w;
      int         since;
      pend = 0; armed = 0; prev_v = 0; strobe_w = 0; since = 0; held = '0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin pend = 0; armed = 0; prev_v = 0; continue; end
         since++;
         if (pend) begin
            check("tx_hold_valid", tx_valid_o, 1);
            check("tx_hold_data", tx_data_o, held);
         end
         if (sel_o) begin
            check("bus_expected", exp_bus.size() != 0, 1);
            if (exp_bus.size() != 0) begin
               b = exp_bus.pop_front();
               check("bus_addr", addr_o, b.a);
               check("bus_wr", wr_o, b.w);
               if (b.w) check("bus_data", data_o, b.d);
            end
            armed = 1; since = 0; strobe_w = wr_o;
         end
         if (tx_valid_o && !prev_v && armed) begin
            check("resp_latency", since, strobe_w ? 1 : RDL + 1);
            armed = 0;
         end
         if (tx_valid_o && tx_ready_i) begin
            check("tx_expected", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) begin
               t = exp_tx.pop_front();
               check("tx_byte", tx_data_o, t);
            end
         end
         pend = tx_valid_o && !tx_ready_i;
         held = tx_data_o;
         prev_v = tx_valid_o;
      end
   end

   task automatic send(input logic [7:0] v);
      @(posedge clk_i); #1;
      rx_data_i = v; rx_valid_i = 1'b1;
      @(posedge clk_i); #1;
      rx_valid_i = 1'b0;
   endtask

   task automatic wr_frame(input logic [31:0] a, input logic [31:0] d);
      exp_bus.push_back('{a: a, d: d, w: 1'b1});
      exp_tx.push_back(8'h4B);
      send(8'h57);
      for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) send(d[i*8 +: 8]);
   endtask

   task automatic rd_frame(input logic [31:0] a, input logic [31:0] d, input logic resp);
      rd_word = d;
      exp_bus.push_back('{a: a, d: '0, w: 1'b0});
      if (resp) for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
      send(8'h52);
      for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_i);
         if (!busy_o && exp_tx.size() == 0 && exp_bus.size() == 0) break;
      end
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_txq"}, exp_tx.size(), 0);
      check({tag, "_busq"}, exp_bus.size(), 0);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk_i); #1; rst_i = 1'b1;
      @(posedge clk_i); #1; rst_i = 1'b0;
      @(negedge clk_i);
      check({tag, "_txv"}, tx_valid_o, 0);
      check({tag, "_txd"}, tx_data_o, 0);
      check({tag, "_sel"}, sel_o, 0);
      check({tag, "_wr"}, wr_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_addr"}, addr_o, 0);
      check({tag, "_data"}, data_o, 0);
   endtask

   initial begin
      do_reset("rst0");
      wr_frame(32'h01104010, 32'h000000AA);
      wait_done("write");
      check("write_addr_hold", addr_o, 32'h01104010);
      check("write_data_hold", data_o, 32'h000000AA);
      bp = 1'b1;
      rd_frame(32'h01204000, 32'h12345678, 1'b1);
      wait_done("read_bp");
      bp = 1'b0;
      exp_tx.push_back(8'h3F);
      send(8'h00);
      wait_done("badop");
      rd_frame(32'hA0000004, 32'hCAFEF00D, 1'b1);
      wait_done("read2");
      send(8'h57); send(8'h01); send(8'h10);
      repeat (TMO + 6) @(posedge clk_i);
      @(negedge clk_i);
      check("timeout_busy", busy_o, 0);
      wr_frame(32'h01104010, 32'h000000AA);
      wait_done("after_tmo");
      send(8'h57); send(8'h01); send(8'h10); send(8'h40);
      do_reset("rst_addr");
      repeat (3) @(posedge clk_i);
      check("rst_addr_busq", exp_bus.size(), 0);
      wr_frame(32'h00000010, 32'h55AA33CC);
      wait_done("after_rst1");
      hold = 1'b1;
      rd_frame(32'h0000BEEF, 32'h87654321, 1'b0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (tx_valid_o) break;
      end
      check("resp_pending", tx_valid_o, 1);
      do_reset("rst_resp");
      hold = 1'b0;
      repeat (3) @(posedge clk_i);
      check("rst_resp_busq", exp_bus.size(), 0);
      rd_frame(32'h00000020, 32'hA5C3E1F0, 1'b1);
      wait_done("after_rst2");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
